fib_checker: RTL and testbench

FIB_CHECKER -- requirements
Module: fib_checker

---
 rtl/fib_checker.sv | 102 ++++++++++
 tb/tb_fib_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fib_checker.sv
// Fibonacci stream checker: learns two seed samples, then predicts and checks
// every further sample, tracking lock, error pulses, fault and saturating totals.
module fib_checker #(
  parameter int W        = 9,
  parameter int LOCK_N   = 3,
  parameter int MAX_MISS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         clear,
  output logic [W-1:0] expect_out,
  output logic         locked,
  output logic         err,
  output logic         fault,
  output logic [7:0]   err_count,
  output logic [15:0]  match_count,
  output logic [1:0]   dbg_state
);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready is combinational and drops while in FAULT or while clear is high.
  typedef enum logic [1:0] {ACQ0 = 2'd0, ACQ1 = 2'd1, CHECK = 2'd2, FAULT = 2'd3} state_t;

  localparam logic [7:0] LOCK_T = 8'(LOCK_N);
  localparam logic [7:0] MISS_T = 8'(MAX_MISS);

  state_t       state;
  logic [W-1:0] prv1;
  logic [W-1:0] prv2;
  logic [7:0]   match_run;
  logic [7:0]   miss_run;
  logic         accept;

  assign in_ready  = (state != FAULT) && !clear;
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACQ0;
      prv1        <= '0;
      prv2        <= '0;
      expect_out  <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      fault       <= 1'b0;
      err_count   <= '0;
      match_count <= '0;
      match_run   <= '0;
      miss_run    <= '0;
    end else begin
      err <= 1'b0;
      if (clear) begin
        state     <= ACQ0;
        locked    <= 1'b0;
        fault     <= 1'b0;
        match_run <= '0;
        miss_run  <= '0;
      end else if (accept) begin
        case (state)
          ACQ0: begin
            prv1       <= in_data;
            expect_out <= in_data + prv2;
            state      <= ACQ1;
          end
          ACQ1: begin
            prv2       <= in_data;
            expect_out <= prv1 + in_data;
            state      <= CHECK;
          end
          CHECK: begin
            // Always resync on the received value, match or not.
            prv1       <= prv2;
            prv2       <= in_data;
            expect_out <= prv2 + in_data;
            if (in_data == expect_out) begin
              if (match_count != 16'hffff) match_count <= match_count + 16'd1;
              miss_run <= '0;
              if (match_run != LOCK_T) match_run <= match_run + 8'd1;
              if ((match_run + 8'd1) >= LOCK_T) locked <= 1'b1;
            end else begin
              err <= 1'b1;
              if (err_count != 8'hff) err_count <= err_count + 8'd1;
              match_run <= '0;
              locked    <= 1'b0;
              miss_run  <= miss_run + 8'd1;
              if ((miss_run + 8'd1) == MISS_T) begin
                state <= FAULT;
                fault <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker: directed steps with a reference model feeding an
// expected-output queue, plus fixed-value checks of the key scenarios.
module tb_fib_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [8:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic [8:0]  expect_out;
  logic        locked;
  logic        err;
  logic        fault;
  logic [7:0]  err_count;
  logic [15:0] match_count;
  logic [1:0]  dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [37:0] exp_q[$];

  // reference model state
  logic [1:0]  m_state;
  logic [8:0]  m_p1, m_p2;
  logic        m_lock, m_fault, m_err;
  logic [7:0]  m_ec;
  logic [15:0] m_mc;
  int          m_mrun, m_xrun;

  fib_checker #(.W(9), .LOCK_N(3), .MAX_MISS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clear(clear), .expect_out(expect_out),
    .locked(locked), .err(err), .fault(fault), .err_count(err_count),
    .match_count(match_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] obs_vec();
    return {dbg_state, fault, locked, err, err_count, match_count, expect_out};
  endfunction

  function automatic logic [8:0] m_sum();
    return m_p1 + m_p2;
  endfunction

  function automatic logic [37:0] model_vec();
    logic [8:0] s;
    s = m_p1 + m_p2;
    return {m_state, m_fault, m_lock, m_err, m_ec, m_mc, s};
  endfunction

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_p1 = '0; m_p2 = '0; m_lock = 0; m_fault = 0; m_err = 0;
    m_ec = '0; m_mc = '0; m_mrun = 0; m_xrun = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 1; in_data = 9'h1ff; clear = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; clear = 0;
    model_reset();
    exp_q.push_back(model_vec());
    chk("reset_outputs", obs_vec(), exp_q.pop_front());
    #1 chk("ready_after_reset", 38'(in_ready), 38'd1);
  endtask

  task automatic step(input logic v, input logic [8:0] d, input logic c);
    logic rdy;
    in_valid = v; in_data = d; clear = c;
    #1;
    rdy = (m_state != 2'd3) && !c;
    chk("in_ready", 38'(in_ready), 38'(rdy));
    m_err = 0;
    if (c) begin
      m_state = 2'd0; m_lock = 0; m_fault = 0; m_mrun = 0; m_xrun = 0;
    end else if (v && rdy) begin
      case (m_state)
        2'd0: begin m_p1 = d; m_state = 2'd1; end
        2'd1: begin m_p2 = d; m_state = 2'd2; end
        2'd2: begin
          if (d == m_sum()) begin
            if (m_mc != 16'hffff) m_mc++;
            m_xrun = 0;
            m_mrun++;
            if (m_mrun >= 3) m_lock = 1;
          end else begin
            m_err = 1;
            if (m_ec != 8'hff) m_ec++;
            m_mrun = 0;
            m_lock = 0;
            m_xrun++;
            if (m_xrun == 4) begin m_state = 2'd3; m_fault = 1; end
          end
          m_p1 = m_p2; m_p2 = d;
        end
        default: ;
      endcase
    end
    exp_q.push_back(model_vec());
    @(posedge clk); #1;
    in_valid = 0; clear = 0;
    chk("outputs", obs_vec(), exp_q.pop_front());
  endtask

  task automatic send(input logic [8:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'd0, 1'b0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; clear = 0;
    model_reset();
    do_reset();

    // Fibonacci stream locks after the third match
    send(9'd1); send(9'd2); send(9'd3); send(9'd5);
    chk("locked_before_8", 38'(locked), 38'd0);
    send(9'd8);
    chk("locked_after_8", 38'(locked), 38'd1);
    send(9'd13);
    chk("stream_mc", 38'(match_count), 38'd4);
    chk("stream_ec", 38'(err_count), 38'd0);
    chk("stream_expect", 38'(expect_out), 38'd21);

    // mismatch while locked
    send(9'd20);
    chk("mis_err", 38'(err), 38'd1);
    chk("mis_ec", 38'(err_count), 38'd1);
    chk("mis_locked", 38'(locked), 38'd0);
    chk("mis_expect", 38'(expect_out), 38'd33);
    idle(1);
    chk("err_one_cycle", 38'(err), 38'd0);

    // clear beats a same-cycle sample
    step(1'b1, 9'd55, 1'b1);
    chk("clear_drop_state", 38'(dbg_state), 38'd0);

    // modulo wrap with gaps between samples
    send(9'd233); idle(2); send(9'd377); idle(1); send(9'd98);
    chk("wrap_expect", 38'(expect_out), 38'd475);
    chk("wrap_mc", 38'(match_count), 38'd5);

    // four consecutive mismatches force FAULT
    for (int i = 0; i < 4; i++) send(m_sum() + 9'd1);
    chk("fault_set", 38'(fault), 38'd1);
    chk("fault_ready", 38'(in_ready), 38'd0);
    send(9'd7); send(9'd9);
    chk("fault_hold_ec", 38'(err_count), 38'd5);
    step(1'b0, 9'd0, 1'b1);
    #1;
    chk("clear_ready", 38'(in_ready), 38'd1);
    chk("clear_state", 38'(dbg_state), 38'd0);
    chk("clear_ec_kept", 38'(err_count), 38'd5);
    chk("clear_mc_kept", 38'(match_count), 38'd5);

    // err_count saturation: 3 misses then 1 match, 100 rounds
    send(9'd1); send(9'd1);
    for (int r = 0; r < 100; r++) begin
      for (int k = 0; k < 3; k++) send(m_sum() + 9'($urandom_range(1, 500)));
      send(m_sum());
    end
    chk("sat_ec", 38'(err_count), 38'd255);
    chk("sat_mc", 38'(match_count), 38'd105);

    // rst mid-CHECK discards everything
    do_reset();
    chk("rst_all_zero", obs_vec(), 38'd0);

    // gapped stream gives the same result as back-to-back
    send(9'd1); idle($urandom_range(1, 3)); send(9'd2); idle($urandom_range(1, 3));
    send(9'd3); idle($urandom_range(1, 3)); send(9'd5); idle($urandom_range(1, 3));
    send(9'd8); idle($urandom_range(1, 3)); send(9'd13); idle($urandom_range(1, 3));
    chk("gap_mc", 38'(match_count), 38'd4);
    chk("gap_expect", 38'(expect_out), 38'd21);
    chk("gap_locked", 38'(locked), 38'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
